// File: rtl/camera_frame_writer.sv
// Producer side of the RGB444 frame buffer: turns the OV7670 byte stream into raster-ordered
// single-cycle BRAM writes, with optional 2:1 decimation of an oversize sensor frame.
module camera_frame_writer #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int PIXEL_BITS   = 12,
  parameter int DECIMATE     = 1,
  parameter int ADDR_BITS    = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
) (
  input  logic                  clk_cam_pclk,
  input  logic                  rst_n,
  input  logic                  capture_en,
  input  logic                  resend,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic [7:0]            cam_data,
  output logic [ADDR_BITS-1:0]  wraddress,
  output logic [PIXEL_BITS-1:0] wrdata,
  output logic                  wren,
  output logic                  capturing,
  output logic                  frame_done,
  output logic                  frame_error
);

  localparam int PTR_W = ADDR_BITS + 1;
  localparam int COL_W = $clog2(IMAGE_WIDTH*2) + 1;
  localparam int ROW_W = $clog2(IMAGE_HEIGHT*2) + 1;
  localparam logic [PTR_W-1:0] TOTAL = PTR_W'(IMAGE_WIDTH*IMAGE_HEIGHT);

  typedef enum logic [1:0] {IDLE, WAIT_VSYNC, ARMED, ACTIVE} state_t;

  state_t           state;
  logic             vsync_q;
  logic             href_q;
  logic             phase;
  logic [3:0]       red_p0;
  logic [COL_W-1:0] sx;
  logic [ROW_W-1:0] sy;
  logic [PTR_W-1:0] ptr;
  logic             overflow;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             keep;
  logic             in_range;

  // Saturating sensor counters so an overlong line/frame can never wrap back into range.
  function automatic logic [COL_W-1:0] col_inc(input logic [COL_W-1:0] v);
    return (&v) ? v : v + COL_W'(1);
  endfunction

  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] v);
    return (&v) ? v : v + ROW_W'(1);
  endfunction

  always_comb begin
    col      = (DECIMATE != 0) ? (sx >> 1) : sx;
    row      = (DECIMATE != 0) ? (sy >> 1) : sy;
    keep     = (DECIMATE == 0) || (!sx[0] && !sy[0]);
    in_range = (col < COL_W'(IMAGE_WIDTH)) && (row < ROW_W'(IMAGE_HEIGHT));
  end

  always_ff @(posedge clk_cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      phase       <= 1'b0;
      red_p0      <= '0;
      sx          <= '0;
      sy          <= '0;
      ptr         <= '0;
      overflow    <= 1'b0;
      wraddress   <= '0;
      wrdata      <= '0;
      wren        <= 1'b0;
      capturing   <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      vsync_q     <= cam_vsync;
      href_q      <= cam_href;
      wren        <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      if (resend) begin
        state     <= capture_en ? WAIT_VSYNC : IDLE;
        capturing <= 1'b0;
        phase     <= 1'b0;
        sx        <= '0;
        sy        <= '0;
        ptr       <= '0;
        overflow  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (capture_en) state <= WAIT_VSYNC;
          end
          WAIT_VSYNC: begin
            if (cam_vsync) begin
              state     <= ARMED;
              capturing <= 1'b1;
            end
          end
          ARMED: begin
            phase    <= 1'b0;
            sx       <= '0;
            sy       <= '0;
            ptr      <= '0;
            overflow <= 1'b0;
            if (!cam_vsync) state <= ACTIVE;
          end
          ACTIVE: begin
            if (cam_vsync && !vsync_q) begin
              // Any kept pixel that could not be stored makes the frame bad even if ptr filled up.
              if (ptr == TOTAL && !overflow) frame_done <= 1'b1;
              else                           frame_error <= 1'b1;
              if (capture_en) begin
                state <= ARMED;
              end else begin
                state     <= IDLE;
                capturing <= 1'b0;
              end
            end else if (cam_href) begin
              phase <= ~phase;
              if (!phase) begin
                red_p0 <= cam_data[3:0];
              end else begin
                sx <= col_inc(sx);
                if (keep) begin
                  if (in_range && ptr < TOTAL) begin
                    // Stage p1: registered BRAM write one cycle after the second byte.
                    wren      <= 1'b1;
                    wrdata    <= PIXEL_BITS'({red_p0, cam_data});
                    wraddress <= ptr[ADDR_BITS-1:0];
                    ptr       <= ptr + PTR_W'(1);
                  end else begin
                    overflow <= 1'b1;
                  end
                end
              end
            end else if (href_q) begin
              sy    <= row_inc(sy);
              sx    <= '0;
              phase <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_camera_frame_writer.sv
// Directed bench for camera_frame_writer: a 4x2 stored frame, one full-size and one decimating instance
// driven from the same camera stream, with a write-by-write reference built from the byte pattern.
module tb_camera_frame_writer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int PB = 12;
  localparam int AB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, capture_en, resend, cam_vsync, cam_href;
  logic [7:0]    cam_data;
  logic [AB-1:0] addr_f, addr_d;
  logic [PB-1:0] data_f, data_d;
  logic          wren_f, wren_d, cap_f, cap_d, done_f, done_d, err_f, err_d;

  camera_frame_writer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_BITS(PB), .DECIMATE(0), .ADDR_BITS(AB)) u_full (
    .clk_cam_pclk(clk), .rst_n(rst_n), .capture_en(capture_en), .resend(resend),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .wraddress(addr_f), .wrdata(data_f), .wren(wren_f), .capturing(cap_f),
    .frame_done(done_f), .frame_error(err_f));

  camera_frame_writer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_BITS(PB), .DECIMATE(1), .ADDR_BITS(AB)) u_dec (
    .clk_cam_pclk(clk), .rst_n(rst_n), .capture_en(capture_en), .resend(resend),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .wraddress(addr_d), .wrdata(data_d), .wren(wren_d), .capturing(cap_d),
    .frame_done(done_d), .frame_error(err_d));

  bit            sel;
  logic          m_wren, m_done, m_err;
  logic [AB-1:0] m_addr;
  logic [PB-1:0] m_data;
  assign m_wren = sel ? wren_d : wren_f;
  assign m_done = sel ? done_d : done_f;
  assign m_err  = sel ? err_d  : err_f;
  assign m_addr = sel ? addr_d : addr_f;
  assign m_data = sel ? data_d : data_f;

  typedef struct {
    bit dec;
    int lines;
    int bpl;
    int last_bpl;
    bit drop_en;
    bit fixed;
    int exp_wr;
    int exp_done;
    int exp_err;
  } vec_t;

  vec_t          vecs[8];
  int            checks = 0;
  int            errors = 0;
  int            n_wr = 0, n_done = 0, n_err = 0;
  int            mptr = 0;
  bit            exp_wr = 1'b0;
  logic [AB-1:0] exp_addr = '0;
  logic [PB-1:0] exp_data = '0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One clock: sample results of the last rising edge on the falling edge, then return to drive.
  task automatic step();
    @(negedge clk);
    if (m_wren) n_wr++;
    if (m_done) n_done++;
    if (m_err)  n_err++;
    if (exp_wr || m_wren) begin
      checks++;
      if (m_wren !== exp_wr || m_addr !== exp_addr || m_data !== exp_data) begin
        errors++;
        $display("FAIL write wren=%0b addr=%0d data=%03h required wren=%0b addr=%0d data=%03h",
                 m_wren, m_addr, m_data, exp_wr, exp_addr, exp_data);
      end
    end
    exp_wr = 1'b0;
  endtask

  task automatic send_byte(input int l, input int b, input bit fixed, input bit dec);
    int c, col, row;
    bit keep;
    c = b / 2;
    cam_href = 1'b1;
    if (b % 2 == 0) begin
      cam_data = fixed ? 8'h0A : {4'hF, 4'(l)};
    end else begin
      cam_data = fixed ? 8'hBC : {4'(c), ~4'(c)};
      keep = dec ? (c % 2 == 0 && l % 2 == 0) : 1'b1;
      col  = dec ? c / 2 : c;
      row  = dec ? l / 2 : l;
      if (keep && col < W && row < H && mptr < W*H) begin
        exp_wr   = 1'b1;
        exp_addr = AB'(mptr);
        exp_data = fixed ? 12'hABC : {4'(l), 4'(c), ~4'(c)};
        mptr++;
      end
    end
    step();
  endtask

  task automatic send_frame(input vec_t v);
    int nb;
    mptr      = 0;
    cam_href  = 1'b0;
    cam_vsync = 1'b1;
    repeat (3) step();
    cam_vsync = 1'b0;
    repeat (2) step();
    for (int l = 0; l < v.lines; l++) begin
      nb = (l == v.lines - 1) ? v.last_bpl : v.bpl;
      for (int b = 0; b < nb; b++) send_byte(l, b, v.fixed, v.dec);
      cam_href = 1'b0;
      repeat (2) step();
      if (v.drop_en && l == 0) capture_en = 1'b0;
    end
    cam_vsync = 1'b1;
    repeat (3) step();
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int w0, d0, e0;
    sel = v.dec;
    w0 = n_wr; d0 = n_done; e0 = n_err;
    send_frame(v);
    chk({name, "_writes"}, n_wr - w0, v.exp_wr);
    chk({name, "_done"}, n_done - d0, v.exp_done);
    chk({name, "_error"}, n_err - e0, v.exp_err);
  endtask

  initial begin
    int d0, e0;
    //          dec lines bpl last drop fixed  wr done err
    vecs[0] = '{0, 2, 8,  8,  0, 1, 8, 1, 0};  // 4x2 of 0x0A,0xBC
    vecs[1] = '{1, 4, 16, 16, 0, 0, 8, 1, 0};  // 8x4 sensor decimated
    vecs[2] = '{0, 2, 8,  6,  0, 0, 7, 0, 1};  // short frame, 7 pixels
    vecs[3] = '{0, 1, 3,  3,  0, 0, 1, 0, 1};  // single 3-byte line
    vecs[4] = '{0, 3, 8,  8,  0, 0, 8, 0, 1};  // extra line past W*H
    vecs[5] = '{1, 4, 20, 20, 0, 0, 8, 0, 1};  // decimated, line too wide
    vecs[6] = '{1, 6, 16, 16, 0, 0, 8, 0, 1};  // decimated, too many rows
    vecs[7] = '{0, 2, 8,  8,  1, 0, 8, 1, 0};  // capture_en drops mid-frame

    rst_n = 1'b0; capture_en = 1'b0; resend = 1'b0;
    cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00; sel = 1'b0;
    repeat (2) step();
    chk("rst_wren", wren_f, 0);
    chk("rst_wraddress", addr_f, 0);
    chk("rst_wrdata", data_f, 0);
    chk("rst_capturing", cap_f, 0);
    chk("rst_frame_done", done_f, 0);
    chk("rst_frame_error", err_f, 0);
    chk("rst_dec_capturing", cap_d, 0);
    rst_n = 1'b1;
    step();
    capture_en = 1'b1;

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
    chk("idle_after_drop_capturing", cap_f, 0);

    // resend in the middle of a line aborts silently; the next frame restarts at address 0
    sel = 1'b0;
    capture_en = 1'b1;
    cam_vsync = 1'b1;
    repeat (2) step();
    cam_vsync = 1'b0;
    repeat (2) step();
    mptr = 0;
    for (int b = 0; b < 5; b++) send_byte(0, b, 1'b0, 1'b0);
    chk("pre_resend_capturing", cap_f, 1);
    d0 = n_done; e0 = n_err;
    cam_href = 1'b1; cam_data = 8'h21; resend = 1'b1;
    step();
    resend = 1'b0;
    chk("resend_wren", wren_f, 0);
    chk("resend_capturing", cap_f, 0);
    repeat (4) step();
    cam_href = 1'b0;
    step();
    cam_vsync = 1'b1;
    repeat (3) step();
    chk("resend_no_done", n_done - d0, 0);
    chk("resend_no_error", n_err - e0, 0);
    run_vec("after_resend", vecs[0]);

    // reset mid-frame, then enable while the sensor is already mid-frame
    cam_vsync = 1'b0;
    repeat (2) step();
    mptr = 0;
    for (int b = 0; b < 4; b++) send_byte(0, b, 1'b1, 1'b0);
    d0 = n_done; e0 = n_err;
    cam_href = 1'b1;
    rst_n = 1'b0;
    step();
    chk("midrst_wren", wren_f, 0);
    chk("midrst_wraddress", addr_f, 0);
    chk("midrst_capturing", cap_f, 0);
    rst_n = 1'b1;
    for (int b = 0; b < 8; b++) begin
      cam_data = (b % 2 == 0) ? 8'h0A : 8'hBC;
      step();
    end
    cam_href = 1'b0;
    repeat (2) step();
    chk("midrst_no_done", n_done - d0, 0);
    chk("midrst_no_error", n_err - e0, 0);
    run_vec("midframe_enable", vecs[0]);
    chk("rearmed_capturing", cap_f, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
